// File: rtl/swap_pkg.sv
// Shared types for the initiator-port swap configuration controller:
// table entry layout, controller state encoding and default field width.
package swap_pkg;

    localparam int LOG_N_INIT_DEF = 2;

    typedef struct packed {
        logic                      sel;
        logic [LOG_N_INIT_DEF-1:0] src;
        logic [LOG_N_INIT_DEF-1:0] tgt;
    } swap_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2,
        APPLY   = 2'd3
    } swap_state_e;

endpackage

// File: rtl/swap_ostd_cnt.sv
// Per-port outstanding-transaction counter: saturating up/down count with
// a zero flag for quiesce detection and a single-cycle misuse flag.
module swap_ostd_cnt #(
    parameter int OUT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic err
);

    localparam logic [OUT_W-1:0] CNT_MAX = '1;
    localparam logic [OUT_W-1:0] CNT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [OUT_W-1:0] cnt_q;
    logic [OUT_W-1:0] cnt_d;

    // Returns {error, next_count}; the count never wraps in either direction.
    function automatic logic [OUT_W:0] sat_step(input logic [OUT_W-1:0] c,
                                                input logic up,
                                                input logic dn);
        logic [OUT_W:0] r;
        r = {1'b0, c};
        if (up && !dn) begin
            if (c == CNT_MAX) r = {1'b1, c};
            else              r = {1'b0, c + CNT_ONE};
        end else if (dn && !up) begin
            if (c == '0) r = {1'b1, c};
            else         r = {1'b0, c - CNT_ONE};
        end
        return r;
    endfunction

    always_comb begin
        {err, cnt_d} = sat_step(cnt_q, inc, dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/swap_cfg_ctrl.sv
// Configuration master for the crossbar swap remapper: shadow table written
// by software, copied to the active outputs only once all initiators are idle.
module swap_cfg_ctrl
    import swap_pkg::*;
#(
    parameter int N_INIT_PORT = 8,
    parameter int LOG_N_INIT  = LOG_N_INIT_DEF,
    parameter int OUT_W       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic [LOG_N_INIT:0]               cfg_port_i,
    input  logic                              cfg_sel_i,
    input  logic [LOG_N_INIT-1:0]             cfg_src_i,
    input  logic [LOG_N_INIT-1:0]             cfg_tgt_i,
    input  logic                              commit_i,
    input  logic [N_INIT_PORT-1:0]            req_hs_i,
    input  logic [N_INIT_PORT-1:0]            rsp_done_i,
    output logic                              block_o,
    output logic                              commit_done_o,
    output logic [N_INIT_PORT-1:0]            select_o,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] source_o,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] target_o,
    output logic                              err_o
);

    typedef struct packed {
        logic                  sel;
        logic [LOG_N_INIT-1:0] src;
        logic [LOG_N_INIT-1:0] tgt;
    } entry_t;

    swap_state_e state_q;
    swap_state_e state_d;

    entry_t shadow_q [N_INIT_PORT];
    entry_t active_q [N_INIT_PORT];
    entry_t wr_entry;

    logic                   wr_acc;
    logic                   wr_bad;
    logic                   load_active;
    logic                   quiet;
    logic                   err_q;
    logic [N_INIT_PORT-1:0] cnt_zero;
    logic [N_INIT_PORT-1:0] cnt_err;

    assign wr_entry = '{sel: cfg_sel_i, src: cfg_src_i, tgt: cfg_tgt_i};
    assign wr_acc   = cfg_valid_i && cfg_ready_o;
    assign wr_bad   = wr_acc && (32'(cfg_port_i) >= N_INIT_PORT);
    assign quiet    = &cnt_zero;

    genvar g;
    generate
        for (g = 0; g < N_INIT_PORT; g++) begin : g_port
            swap_ostd_cnt #(
                .OUT_W (OUT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (req_hs_i[g]),
                .dec   (rsp_done_i[g]),
                .zero  (cnt_zero[g]),
                .err   (cnt_err[g])
            );

            assign select_o[g]                          = active_q[g].sel;
            assign source_o[g*LOG_N_INIT +: LOG_N_INIT] = active_q[g].src;
            assign target_o[g*LOG_N_INIT +: LOG_N_INIT] = active_q[g].tgt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The active table is loaded on the edge leaving a quiet DRAIN, so APPLY
    // is the single cycle in which the new routing is first visible.
    always_comb begin
        state_d       = state_q;
        block_o       = 1'b0;
        cfg_ready_o   = 1'b0;
        commit_done_o = 1'b0;
        load_active   = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (commit_i) state_d = PENDING;
            end
            PENDING: begin
                block_o     = 1'b1;
                cfg_ready_o = 1'b1;
                state_d     = DRAIN;
            end
            DRAIN: begin
                block_o = 1'b1;
                if (quiet) begin
                    load_active = 1'b1;
                    state_d     = APPLY;
                end
            end
            APPLY: begin
                block_o       = 1'b1;
                commit_done_o = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range indices match no entry, so such writes fall away here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INIT_PORT; i++) shadow_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_INIT_PORT; i++) begin
                if (wr_acc && (32'(cfg_port_i) == i)) shadow_q[i] <= wr_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INIT_PORT; i++) active_q[i] <= '0;
        end else if (load_active) begin
            for (int i = 0; i < N_INIT_PORT; i++) active_q[i] <= shadow_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   err_q <= 1'b0;
        else if (wr_bad || |cnt_err)  err_q <= 1'b1;
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_swap_cfg_ctrl.sv
// Directed bench for swap_cfg_ctrl: write/commit flow, drain timing,
// ignored commits, bad index, counter limits and reset during a commit.
module tb_swap_cfg_ctrl;

    localparam int N  = 8;
    localparam int L  = 3;
    localparam int OW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [L:0]       cfg_port;
    logic             cfg_sel;
    logic [L-1:0]     cfg_src;
    logic [L-1:0]     cfg_tgt;
    logic             commit;
    logic [N-1:0]     req_hs;
    logic [N-1:0]     rsp_done;
    logic             block;
    logic             done;
    logic [N-1:0]     select;
    logic [N*L-1:0]   source;
    logic [N*L-1:0]   target;
    logic             err;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    swap_cfg_ctrl #(
        .N_INIT_PORT (N),
        .LOG_N_INIT  (L),
        .OUT_W       (OW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_port_i    (cfg_port),
        .cfg_sel_i     (cfg_sel),
        .cfg_src_i     (cfg_src),
        .cfg_tgt_i     (cfg_tgt),
        .commit_i      (commit),
        .req_hs_i      (req_hs),
        .rsp_done_i    (rsp_done),
        .block_o       (block),
        .commit_done_o (done),
        .select_o      (select),
        .source_o      (source),
        .target_o      (target),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [L:0] p, input logic s,
                          input logic [L-1:0] sr, input logic [L-1:0] tg);
        cfg_valid = v;
        cfg_port  = p;
        cfg_sel   = s;
        cfg_src   = sr;
        cfg_tgt   = tg;
    endtask

    initial begin
        rst_n    = 1'b0;
        commit   = 1'b0;
        req_hs   = '0;
        rsp_done = '0;
        set_wr(1'b0, '0, 1'b0, '0, '0);

        // Reset state
        cyc(); cyc();
        chk("rst_ready",  64'(cfg_ready), 64'(1));
        chk("rst_block",  64'(block),     64'(0));
        chk("rst_done",   64'(done),      64'(0));
        chk("rst_select", 64'(select),    64'(0));
        chk("rst_source", 64'(source),    64'(0));
        chk("rst_target", 64'(target),    64'(0));
        chk("rst_err",    64'(err),       64'(0));
        rst_n = 1'b1;
        cyc();

        // Write port 3 then commit with all ports quiet
        set_wr(1'b1, 4'd3, 1'b1, 3'd1, 3'd2);
        chk("t1_ready", 64'(cfg_ready), 64'(1));
        cyc();
        set_wr(1'b0, '0, 1'b0, '0, '0);
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        chk("t1_block_c1", 64'(block),  64'(1));
        chk("t1_sel_hold", 64'(select), 64'(0));
        cyc();
        chk("t1_done_c2",  64'(done),   64'(0));
        cyc();
        chk("t1_done_c3",  64'(done),   64'(1));
        chk("t1_select",   64'(select), 64'h08);
        chk("t1_source",   64'(source), 64'h000200);
        chk("t1_target",   64'(target), 64'h000400);
        cyc();
        chk("t1_done_c4",  64'(done),   64'(0));
        chk("t1_block_c4", 64'(block),  64'(0));

        // Two outstanding on port 5, write in the commit cycle, extra commit in DRAIN
        req_hs[5] = 1'b1;
        cyc(); cyc();
        req_hs[5] = 1'b0;
        commit = 1'b1;
        set_wr(1'b1, 4'd6, 1'b1, 3'd5, 3'd7);
        cyc();
        commit = 1'b0;
        set_wr(1'b0, '0, 1'b0, '0, '0);
        done_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            commit      = (k == 4);
            rsp_done[5] = (k == 6) || (k == 9);
            if (k == 1)  chk("t2_block_c1", 64'(block), 64'(1));
            if (k == 5)  chk("t2_ready_drain", 64'(cfg_ready), 64'(0));
            if (k == 10) begin
                chk("t2_sel_c10", 64'(select), 64'h08);
                chk("t2_block_c10", 64'(block), 64'(1));
            end
            if (k == 11) begin
                chk("t2_done_c11", 64'(done),   64'(1));
                chk("t2_select",   64'(select), 64'h48);
                chk("t2_source",   64'(source), 64'h140200);
                chk("t2_target",   64'(target), 64'h1C0400);
            end
            if (k == 12) chk("t2_block_c12", 64'(block), 64'(0));
            done_cnt += int'(done);
            cyc();
        end
        commit   = 1'b0;
        rsp_done = '0;
        chk("t2_one_done", 64'(done_cnt), 64'(1));

        // Simultaneous req/rsp on port 0 keeps the count at 1
        req_hs[0] = 1'b1;
        cyc();
        rsp_done[0] = 1'b1;
        commit      = 1'b1;
        cyc();
        req_hs   = '0;
        rsp_done = '0;
        commit   = 1'b0;
        repeat (6) cyc();
        chk("t3_stuck_block", 64'(block), 64'(1));
        chk("t3_stuck_done",  64'(done),  64'(0));
        rsp_done[0] = 1'b1;
        cyc();
        rsp_done[0] = 1'b0;
        chk("t3_done_early", 64'(done), 64'(0));
        cyc();
        chk("t3_done", 64'(done), 64'(1));
        cyc();

        // Out-of-range index is accepted, dropped and flagged
        chk("t4_err_before", 64'(err), 64'(0));
        set_wr(1'b1, 4'd8, 1'b1, 3'd7, 3'd7);
        chk("t4_ready", 64'(cfg_ready), 64'(1));
        cyc();
        set_wr(1'b0, '0, 1'b0, '0, '0);
        chk("t4_err_set", 64'(err), 64'(1));
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        cyc(); cyc();
        chk("t4_done",   64'(done),   64'(1));
        chk("t4_select", 64'(select), 64'h48);
        chk("t4_source", 64'(source), 64'h140200);
        chk("t4_target", 64'(target), 64'h1C0400);
        repeat (3) cyc();
        chk("t4_err_sticky", 64'(err), 64'(1));

        // Reset while in DRAIN
        req_hs[1] = 1'b1;
        cyc();
        req_hs[1] = 1'b0;
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        cyc(); cyc();
        chk("t5_block_drain", 64'(block), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_block_rst",  64'(block),     64'(0));
        chk("t5_select_rst", 64'(select),    64'(0));
        chk("t5_source_rst", 64'(source),    64'(0));
        chk("t5_target_rst", 64'(target),    64'(0));
        chk("t5_err_rst",    64'(err),       64'(0));
        chk("t5_ready_rst",  64'(cfg_ready), 64'(1));
        cyc();
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (6) begin
            cyc();
            done_cnt += int'(done);
        end
        chk("t5_no_done",    64'(done_cnt), 64'(0));
        chk("t5_block_idle", 64'(block),    64'(0));

        // Saturation at the counter maximum
        req_hs[7] = 1'b1;
        repeat (15) cyc();
        chk("t6_err_at_max", 64'(err), 64'(0));
        cyc();
        req_hs[7] = 1'b0;
        chk("t6_err_sat", 64'(err), 64'(1));

        // Decrement of an empty counter
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t7_err_clear", 64'(err), 64'(0));
        rsp_done[2] = 1'b1;
        cyc();
        rsp_done[2] = 1'b0;
        chk("t7_err_underflow", 64'(err), 64'(1));
        chk("t7_quiet_commit_ready", 64'(cfg_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
